// File: rtl/dmem_mon_pkg.sv
// Shared types for the data-memory capture monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  // One captured write, as queued towards the consumer
  typedef struct packed {
    logic [2:0]  win;
    logic [5:0]  idx;
    logic [31:0] data;
    logic [3:0]  wen;
    logic [15:0] cycle;
  } rec_t;

  localparam logic [3:0] WEN_WORD = 4'b1111;

endpackage

// File: rtl/dmem_capture_monitor_fifo.sv
// Generic synchronous FIFO (DEPTH power of two, >= 2) with synchronous clear.
// Latency: a push is visible at the head one edge later; head is a register read.
// Backpressure: push while full is dropped (drop_o) unless a pop happens in the same cycle.
module mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the push needs
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;
  // Head reads as zero when empty so idle outputs are clean
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage write; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dmem_capture_monitor.sv
// Snoops data-bus writes into NUM_WIN shadow windows, counts them and queues timestamped records.
// Latency: a hit is visible in shadow/counts/win_full/FIFO one edge later; rd_data is 1-cycle registered.
// Backpressure: records wait for rec_ready; a push into a full FIFO is dropped and sets overflow.
module dmem_capture_monitor
  import dmem_mon_pkg::*;
#(
  parameter int                    NUM_WIN    = 3,
  parameter int                    WIN_WORDS  = 4,
  parameter logic [NUM_WIN*32-1:0] WIN_BASE   = {32'h420, 32'h410, 32'h400},
  parameter int                    FIFO_DEPTH = 8,
  parameter int                    MAX_CYCLES = 800
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [31:0]             d_mem_addr,
  input  logic [31:0]             d_mem_wdata,
  input  logic [3:0]              d_mem_wen,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [2:0]              rec_win,
  output logic [5:0]              rec_idx,
  output logic [31:0]             rec_data,
  output logic [3:0]              rec_wen,
  output logic [15:0]             rec_cycle,
  input  logic [2:0]              rd_win,
  input  logic [5:0]              rd_idx,
  output logic [31:0]             rd_data,
  output logic [NUM_WIN-1:0]      win_full,
  output logic [NUM_WIN*16-1:0]   win_count,
  output logic                    overflow,
  output logic                    done,
  output logic                    timeout
);

  localparam int          SH_WORDS  = NUM_WIN * WIN_WORDS;
  localparam int          SH_AW     = (SH_WORDS > 1) ? $clog2(SH_WORDS) : 1;
  localparam logic [31:0] WIN_BYTES = 32'(4 * WIN_WORDS);

  state_e              state_q;
  logic [15:0]         cycle_q;
  logic                done_q, timeout_q, overflow_q;
  logic [31:0]         shadow_q [SH_WORDS];
  logic [SH_WORDS-1:0] valid_q, valid_d;
  logic [15:0]         cnt_q [NUM_WIN];
  logic [31:0]         rd_data_q;

  logic                hit, hit_any;
  logic [2:0]          hit_win;
  logic [5:0]          hit_idx;
  logic [31:0]         base, off;
  logic [SH_AW-1:0]    sh_wr_addr, sh_rd_addr;
  logic                rd_ok;
  rec_t                push_rec, head_rec;
  logic                fifo_empty, fifo_full, fifo_drop;

  // Window decode: scan high to low so the lowest overlapping window wins
  always_comb begin
    hit_any = 1'b0;
    hit_win = '0;
    hit_idx = '0;
    base    = '0;
    off     = '0;
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      base = WIN_BASE[32*w +: 32];
      off  = d_mem_addr - base;
      if (d_mem_addr >= base && off < WIN_BYTES) begin
        hit_any = 1'b1;
        hit_win = 3'(w);
        hit_idx = off[7:2];
      end
    end
    // A start in RUN restarts the run and swallows that cycle's write
    hit = hit_any && (state_q == ST_RUN) && !start &&
          (d_mem_wen != 4'b0000) && (d_mem_addr[1:0] == 2'b00);
  end

  assign sh_wr_addr = SH_AW'(32'(hit_win) * WIN_WORDS + 32'(hit_idx));
  assign sh_rd_addr = SH_AW'(32'(rd_win) * WIN_WORDS + 32'(rd_idx));
  assign rd_ok      = (32'(rd_win) < NUM_WIN) && (32'(rd_idx) < WIN_WORDS);

  // Next valid bits: only a full-word write marks a word as written
  always_comb begin
    valid_d = valid_q;
    if (hit && d_mem_wen == WEN_WORD) valid_d[sh_wr_addr] = 1'b1;
  end

  // Shadow RAM: byte-lane merge on a hit, wiped when a run starts
  always_ff @(posedge clk) begin
    if (start) begin
      for (int i = 0; i < SH_WORDS; i++) shadow_q[i] <= '0;
    end else if (hit) begin
      for (int b = 0; b < 4; b++) begin
        if (d_mem_wen[b]) shadow_q[sh_wr_addr][8*b +: 8] <= d_mem_wdata[8*b +: 8];
      end
    end
  end

  // Readback register sees the shadow before any same-edge write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_ok ? shadow_q[sh_rd_addr] : '0;
  end

  // Valid bits, saturating per-window counters and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      overflow_q <= 1'b0;
      for (int w = 0; w < NUM_WIN; w++) cnt_q[w] <= '0;
    end else if (start) begin
      valid_q    <= '0;
      overflow_q <= 1'b0;
      for (int w = 0; w < NUM_WIN; w++) cnt_q[w] <= '0;
    end else begin
      valid_q <= valid_d;
      if (fifo_drop) overflow_q <= 1'b1;
      for (int w = 0; w < NUM_WIN; w++) begin
        if (hit && hit_win == 3'(w) && cnt_q[w] != 16'hFFFF) cnt_q[w] <= cnt_q[w] + 16'd1;
      end
    end
  end

  // Run FSM with registered done/timeout; completion beats timeout on the last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cycle_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (start) begin
      state_q   <= ST_RUN;
      cycle_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cycle_q != 16'hFFFF) cycle_q <= cycle_q + 16'd1;
          if (&valid_d) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (cycle_q == 16'(MAX_CYCLES - 1)) begin
            state_q   <= ST_TIMEOUT;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign push_rec = '{win: hit_win, idx: hit_idx, data: d_mem_wdata, wen: d_mem_wen, cycle: cycle_q};

  mon_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start),
    .push_i     (hit),
    .push_dat_i (push_rec),
    .pop_i      (rec_ready),
    .head_dat_o (head_rec),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .drop_o     (fifo_drop)
  );

  for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
    assign win_full[w]           = &valid_q[w*WIN_WORDS +: WIN_WORDS];
    assign win_count[16*w +: 16] = cnt_q[w];
  end

  assign rec_valid = !fifo_empty;
  assign rec_win   = head_rec.win;
  assign rec_idx   = head_rec.idx;
  assign rec_data  = head_rec.data;
  assign rec_wen   = head_rec.wen;
  assign rec_cycle = head_rec.cycle;
  assign rd_data   = rd_data_q;
  assign overflow  = overflow_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

  // Full status is informational; the drop decision lives in the FIFO
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_dmem_capture_monitor.sv
// Directed bench for dmem_capture_monitor: decode table plus multi-cycle sequences.
// Latency: checks are taken 1 ns after the rising edge that captured the stimulus.
// Backpressure: rec_ready is driven explicitly per sequence.
module tb_dmem_capture_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] d_mem_addr, d_mem_wdata;
  logic [3:0]  d_mem_wen;
  logic        rec_valid, rec_ready;
  logic [2:0]  rec_win;
  logic [5:0]  rec_idx;
  logic [31:0] rec_data;
  logic [3:0]  rec_wen;
  logic [15:0] rec_cycle;
  logic [2:0]  rd_win;
  logic [5:0]  rd_idx;
  logic [31:0] rd_data;
  logic [2:0]  win_full;
  logic [47:0] win_count;
  logic        overflow, done, timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_capture_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata), .d_mem_wen(d_mem_wen),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_win(rec_win), .rec_idx(rec_idx),
    .rec_data(rec_data), .rec_wen(rec_wen), .rec_cycle(rec_cycle),
    .rd_win(rd_win), .rd_idx(rd_idx), .rd_data(rd_data),
    .win_full(win_full), .win_count(win_count), .overflow(overflow),
    .done(done), .timeout(timeout)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    bit          hit;
    logic [2:0]  win;
    logic [5:0]  idx;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    d_mem_addr  = a;
    d_mem_wdata = d;
    d_mem_wen   = we;
    tick();
    d_mem_wen   = 4'b0000;
  endtask

  // Pop n records expecting data first, first+4, ...; then the FIFO must be empty
  task automatic drain(input string name, input logic [31:0] first, input int n);
    rec_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({name, "_valid"}, 64'(rec_valid), 64'd1);
      chk({name, "_data"}, 64'(rec_data), 64'(first + 32'(4 * i)));
      tick();
    end
    chk({name, "_empty"}, 64'(rec_valid), 64'd0);
    rec_ready = 1'b0;
  endtask

  initial begin
    logic [47:0] exp_cnt;
    logic [31:0] a;

    tbl[0] = '{32'h400, 4'hF, 1'b1, 3'd0, 6'd0};
    tbl[1] = '{32'h40C, 4'hF, 1'b1, 3'd0, 6'd3};
    tbl[2] = '{32'h410, 4'hF, 1'b1, 3'd1, 6'd0};
    tbl[3] = '{32'h42C, 4'hF, 1'b1, 3'd2, 6'd3};
    tbl[4] = '{32'h3FC, 4'hF, 1'b0, 3'd0, 6'd0};
    tbl[5] = '{32'h430, 4'hF, 1'b0, 3'd0, 6'd0};
    tbl[6] = '{32'h402, 4'hF, 1'b0, 3'd0, 6'd0};
    tbl[7] = '{32'h414, 4'h0, 1'b0, 3'd0, 6'd0};
    tbl[8] = '{32'h418, 4'h4, 1'b1, 3'd1, 6'd2};

    rst_n = 1'b0; start = 1'b0; rec_ready = 1'b0;
    d_mem_addr = '0; d_mem_wdata = '0; d_mem_wen = '0;
    rd_win = '0; rd_idx = '0;
    tick(); tick();
    chk("rst_rec_valid", 64'(rec_valid), 64'd0);
    chk("rst_rec_data", 64'(rec_data), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_win_full", 64'(win_full), 64'd0);
    chk("rst_win_count", 64'(win_count), 64'd0);
    chk("rst_flags", 64'({overflow, done, timeout}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Writes before any start are ignored
    wr(32'h400, 32'h1, 4'hF);
    chk("idle_ignored", 64'(win_count), 64'd0);

    // Decode table: one write per fresh run
    for (int i = 0; i < 9; i++) begin
      do_start();
      wr(tbl[i].addr, tbl[i].addr ^ 32'hA5A5_0000, tbl[i].wen);
      exp_cnt = tbl[i].hit ? (48'd1 << (16 * tbl[i].win)) : 48'd0;
      chk($sformatf("tbl%0d_count", i), 64'(win_count), 64'(exp_cnt));
      chk($sformatf("tbl%0d_valid", i), 64'(rec_valid), 64'(tbl[i].hit));
      if (tbl[i].hit) begin
        chk($sformatf("tbl%0d_win", i), 64'(rec_win), 64'(tbl[i].win));
        chk($sformatf("tbl%0d_idx", i), 64'(rec_idx), 64'(tbl[i].idx));
        chk($sformatf("tbl%0d_data", i), 64'(rec_data), 64'(tbl[i].addr ^ 32'hA5A5_0000));
        chk($sformatf("tbl%0d_wen", i), 64'(rec_wen), 64'(tbl[i].wen));
      end else begin
        chk($sformatf("tbl%0d_data0", i), 64'(rec_data), 64'd0);
      end
    end

    // Full run: 12 word writes, records consumed as they arrive
    do_start();
    rec_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a = 32'h400 + 32'(4 * i);
      chk($sformatf("run_done_pre%0d", i), 64'(done), 64'd0);
      wr(a, a, 4'hF);
      chk($sformatf("run_rec%0d_data", i), 64'(rec_data), 64'(a));
      chk($sformatf("run_rec%0d_cycle", i), 64'(rec_cycle), 64'(i));
    end
    chk("run_done", 64'(done), 64'd1);
    chk("run_timeout", 64'(timeout), 64'd0);
    chk("run_win_full", 64'(win_full), 64'd7);
    chk("run_win_count", 64'(win_count), 64'h0004_0004_0004);
    rd_win = 3'd1; rd_idx = 6'd2;
    tick();
    chk("run_rd_1_2", 64'(rd_data), 64'h418);
    chk("run_fifo_empty", 64'(rec_valid), 64'd0);
    rec_ready = 1'b0;

    // Partial writes merge bytes but never mark the word valid
    do_start();
    wr(32'h400, 32'hAAAA_0000, 4'hF);
    wr(32'h408, 32'hAAAA_0008, 4'hF);
    wr(32'h40C, 32'hAAAA_000C, 4'hF);
    wr(32'h404, 32'h1122_3344, 4'b1101);
    wr(32'h404, 32'h0000_AB00, 4'b0010);
    rd_win = 3'd0; rd_idx = 6'd1;
    tick();
    chk("sb_merge", 64'(rd_data), 64'h1122_AB44);
    chk("sb_win_full", 64'(win_full), 64'd0);
    chk("sb_count0", 64'(win_count[15:0]), 64'd5);
    chk("sb_done", 64'(done), 64'd0);

    // Timeout with no writes
    do_start();
    repeat (799) tick();
    chk("to_pre", 64'(timeout), 64'd0);
    tick();
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_done", 64'(done), 64'd0);

    // Overflow: 10 hits with no consumer, first 8 kept
    do_start();
    for (int i = 0; i < 10; i++) begin
      a = 32'h400 + 32'(4 * i);
      wr(a, a, 4'hF);
    end
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(win_count), 64'h0002_0004_0004);
    chk("ovf_head_cycle", 64'(rec_cycle), 64'd0);
    drain("ovf_drain", 32'h400, 8);

    // Pop concurrent with push into a full FIFO is not a drop
    do_start();
    for (int i = 0; i < 8; i++) begin
      a = 32'h400 + 32'(4 * i);
      wr(a, a, 4'hF);
    end
    chk("pp_full_noovf", 64'(overflow), 64'd0);
    rec_ready = 1'b1;
    wr(32'h420, 32'h420, 4'hF);
    rec_ready = 1'b0;
    chk("pp_noovf", 64'(overflow), 64'd0);
    chk("pp_head", 64'(rec_data), 64'h404);
    drain("pp_drain", 32'h404, 8);

    // Asynchronous reset mid-run
    do_start();
    for (int i = 0; i < 5; i++) begin
      a = 32'h400 + 32'(4 * i);
      wr(a, a, 4'hF);
    end
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(rec_valid), 64'd0);
    chk("arst_count", 64'(win_count), 64'd0);
    chk("arst_full", 64'(win_full), 64'd0);
    tick();
    rst_n = 1'b1;
    wr(32'h410, 32'h55, 4'hF);
    chk("arst_idle_ignored", 64'(win_count), 64'd0);
    do_start();
    wr(32'h410, 32'h66, 4'hF);
    chk("arst_rerun_count", 64'(win_count), 64'h0000_0001_0000);
    chk("arst_rerun_win", 64'(rec_win), 64'd1);
    chk("arst_rerun_cycle", 64'(rec_cycle), 64'd0);

    // Start while in RUN discards that cycle's write
    d_mem_addr = 32'h420; d_mem_wdata = 32'h77; d_mem_wen = 4'hF;
    do_start();
    d_mem_wen = 4'h0;
    chk("restart_count", 64'(win_count), 64'd0);
    chk("restart_valid", 64'(rec_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_capture_monitor.md
# dmem_capture_monitor

Synthesizable, parametrised data-memory write monitor that snoops the CPU data bus (`d_mem_*`) and captures writes to `NUM_WIN` result windows of `WIN_WORDS` words each. It keeps a byte-merged shadow copy of every window, per-window write counters, and a timestamped record FIFO. It also detects run completion or timeout. It sits beside `cpu_top` in test and FPGA builds and replaces hand-written bench-side result scraping.

## Interface
- `NUM_WIN`, default 3: number of capture windows, 1..8.
- `WIN_WORDS`, default 4: words per window, power of two, 1..64.
- `WIN_BASE`, default {32'h420, 32'h410, 32'h400}: packed `NUM_WIN`×32 word-aligned base addresses; window w occupies bits [32w+31:32w].
- `FIFO_DEPTH`, default 8: record FIFO entries, power of two.
- `MAX_CYCLES`, default 800: timeout in cycles after `start`.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that arms the run.
- `d_mem_addr`  in  32  snooped byte address.
- `d_mem_wdata`  in  32  snooped write data.
- `d_mem_wen`  in  4  snooped byte-lane enables; bit i maps to wdata[8i+7:8i].
- `rec_valid`  out  1  FIFO head is valid.
- `rec_ready`  in  1  consumer accepts the head record.
- `rec_win`  out  3  window index of the head record.
- `rec_idx`  out  6  word index of the head record.
- `rec_data`  out  32  raw `d_mem_wdata` of the head record.
- `rec_wen`  out  4  byte enables of the head record.
- `rec_cycle`  out  16  run-cycle timestamp of the head record.
- `rd_win`, `rd_idx`  in  3 / 6  shadow readback address.
- `rd_data`  out  32  shadow word, registered, 1-cycle latency.
- `win_full`  out  `NUM_WIN`  every word of window w has been written at least once.
- `win_count`  out  `NUM_WIN`×16  per-window accepted-write counts, saturating.
- `overflow`  out  1  sticky flag: at least one record was dropped.
- `done`  out  1  asserted in DONE.
- `timeout`  out  1  asserted in TIMEOUT.

## Operation
- State machine states: IDLE, RUN, DONE, TIMEOUT.
  - IDLE → RUN on `start`. Entering RUN clears the shadow, valid bits, counters, FIFO, `overflow` and the cycle counter.
  - RUN → DONE when `&win_full`.
  - RUN → TIMEOUT when `cycle == MAX_CYCLES-1` and `win_full` is not all ones.
  - DONE and TIMEOUT → RUN on `start`. Writes are ignored in IDLE, DONE and TIMEOUT.
- Hit condition: state is RUN, `d_mem_wen != 0`, `d_mem_addr[1:0]==0`, and `WIN_BASE[w] <= addr < WIN_BASE[w] + 4*WIN_WORDS`.
  - The word index is `(addr - base) >> 2`.
  - If windows overlap, the lowest w wins.
  - Misaligned or out-of-window writes are ignored.
- On a hit:
  - Merge only the enabled byte lanes into the shadow word.
  - Set that word's valid bit only when `d_mem_wen == 4'b1111`. Partial writes update data but not `win_full`.
  - Increment `win_count[w]`, saturating at 16'hFFFF.
  - Push a record {w, idx, wdata, wen, cycle}.
- FIFO behaviour:
  - A push when full drops the record and sets `overflow`. Shadow and counters still update.
  - A simultaneous pop and push when full is accepted with no drop.
  - Pop happens when `rec_valid && rec_ready`.
  - FIFO draining continues in DONE and TIMEOUT.
- The cycle counter is 16-bit, counts RUN cycles from 0 and saturates.
- A `start` pulse while in RUN restarts the run; any write in that same cycle is discarded.

## Timing
- Reset values:
  - state is IDLE;
  - all outputs are 0: `rec_valid`, `rec_*`, `rd_data`, `win_full`, `win_count`, `overflow`, `done`, `timeout`;
  - the shadow RAM is not reset and is cleared on `start`.
- Capture latency: a hit on edge N is visible on edge N+1 in the shadow, `win_count` and `win_full`, with `rec_valid` high if the FIFO was empty.
- `done`/`timeout` assert one cycle after the completing write or the final cycle.
- `rd_data` reflects the shadow as of the previous edge (read-before-write on a collision).
- `rec_*` outputs are held stable while `rec_valid && !rec_ready`.
- Asserting `rst_n` low mid-run returns to IDLE immediately and drops the FIFO contents.

## Structure
- Package `dmem_mon_pkg`: state enum, record struct (win, idx, data, wen, cycle), and `WEN_WORD = 4'b1111`.
- Sub-module `mon_fifo`: generic synchronous FIFO (width, depth) with full, empty, and push-while-full-with-pop.
- The top level holds window decode, shadow/valid arrays, counters and the state machine.

## Test plan
- Defaults; `start`; 12 full-word writes to 0x400..0x42C with data = addr → `done` is 1 one cycle after the last write, `win_full=3'b111`, `rd_data(1,2)=0x418`, 12 records are popped in order.
- `sb`-style `wen=4'b0010` of 0x0000AB00 to 0x404 over an old value of 0x11223344 → shadow = 0x1122AB44, valid bit stays 0, `win_count[0]` increments.
- `start` then no writes → `timeout` is 1 at run cycle 800 and `done` is 0.
- `rec_ready=0` and 10 hits → 8 records held and `overflow=1`; then pop while writing with the FIFO full → no additional drop.
- Writes to 0x3FC, 0x430 and 0x402 → all ignored, every `win_count` stays 0.
- `rst_n` pulse low mid-run after 5 hits → immediate IDLE, `rec_valid=0`, counts are 0; a following `start` runs cleanly.
